sp3_rx_slide_align: RTL
=======================

// Module: sp3_rx_slide_align
//
// PURPOSE
// - Word-alignment controller between the MGT RX (32b @ mgtclk) and sp3_demux.
// - While SPROCKET3 sends its interleaved training word, pulses the MGT RXSLIDE
//   input until mgtword_in equals TRAIN_PATTERN, then confirms the lock.
// - Forwards the raw word, registered, to sp3_demux.mgtword.
// - Reports lock, failure and slide count to slow control.
//
// PARAMETERS
// TRAIN_PATTERN  32'hA5C3_3C5A  aligned interleaved training word expected on mgtword_in
// SLIDE_WAIT     32             mgtclk cycles between rx_slide pulses (UG576 min 32)
// LOCK_COUNT     8              consecutive matches required to declare lock (>=1)
// MAX_SLIDES     32             slides attempted before FAIL (<=63)
//
// PORTS
// mgtclk        in   1   MGT RX user clock
// reset         in   1   async active-high reset
// mgtword_in    in   32  raw RX word from MGT
// align_en      in   1   level; 1 = run alignment, 0 = return to IDLE
// mgtword_out   out  32  mgtword_in delayed 1 cycle, to sp3_demux
// rx_slide      out  1   one-cycle pulse to MGT RXSLIDE
// locked        out  1   1 while in LOCKED
// align_fail    out  1   1 while in FAIL
// slide_cnt     out  6   slides issued in current attempt
// total_slides  out  16  only with SP3_SLIDE_STATS_EN (see CONFIGURATION)
//
// BEHAVIOUR
// - Interface: reset reset, asynchronous, active-high; clock mgtclk.
// - Reset values: mgtword_out=0, rx_slide=0, locked=0, align_fail=0,
//   slide_cnt=0, state=IDLE, internal counters=0.
//   Reset mid-operation aborts immediately; no rx_slide pulse may follow.
// - mgtword_out <= mgtword_in every cycle.
//   - Latency 1. Independent of state.
// - match = (mgtword_in == TRAIN_PATTERN), combinational, sampled every cycle.
// - FSM. align_en==0 forces IDLE next cycle from any state, with priority over all else.
//   - IDLE: outputs 0. If align_en: slide_cnt<=0, go to SEARCH.
//   - SEARCH:
//     - match: good_cnt<=1. Go to LOCKED if LOCK_COUNT==1, else VERIFY.
//     - no match and slide_cnt==MAX_SLIDES: go to FAIL.
//     - otherwise: go to SLIDE.
//   - SLIDE (1 cycle): rx_slide=1, slide_cnt+=1, wait_cnt<=SLIDE_WAIT-1, go to WAIT.
//   - WAIT: rx_slide=0. Decrement wait_cnt; match is ignored. At wait_cnt==0, go to SEARCH.
//   - VERIFY:
//     - match: good_cnt+=1. At good_cnt==LOCK_COUNT-1 with match, go to LOCKED.
//     - mismatch: go to SLIDE if slide_cnt<MAX_SLIDES, else FAIL.
//   - LOCKED: locked=1. Holds regardless of data until align_en falls.
//   - FAIL: align_fail=1. Holds until align_en falls.
// - rx_slide is never high on two cycles less than SLIDE_WAIT+1 apart.
// - slide_cnt saturates at MAX_SLIDES. It holds its value in LOCKED/FAIL for readback.
// - align_en toggled 1->0->1: one IDLE cycle, then slide_cnt restarts at 0.
//
// CONFIGURATION
// - SP3_SLIDE_STATS_EN defined:
//   - total_slides port exists and counts every rx_slide pulse since reset.
//   - It saturates at 16'hFFFF and is not cleared by align_en.
// - SP3_SLIDE_STATS_EN undefined: total_slides port and its counter are absent.
//   All other behaviour is identical.
//
// TESTING
// - Pattern present from the first cycle after align_en=1:
//   no rx_slide; locked=1 after LOCK_COUNT=8 matching cycles; slide_cnt=0.
// - MGT model rotates its output 1 bit per rx_slide, starting 5 bits off:
//   exactly 5 rx_slide pulses, each 33 cycles apart; then locked=1, slide_cnt=5.
// - Pattern never present:
//   32 pulses, then align_fail=1, slide_cnt=32, rx_slide stays 0.
// - One corrupted word at the 4th VERIFY cycle:
//   rx_slide pulses on the next cycle; lock is achieved only after 8 fresh matches.
// - Reset asserted during WAIT (mid-slide sequence):
//   all outputs 0 asynchronously; after release, IDLE and no pulse until align_en re-rises.
// - mgtword_in = 32'h1234_5678:
//   mgtword_out = 32'h1234_5678 one cycle later in every state.
//   With SP3_SLIDE_STATS_EN, after tests 2 and 3 without reset, total_slides=37.

Source files
------------

// File: rtl/sp3_rx_slide_align.sv
// ---------------------------------------------------------------------------
// sp3_rx_slide_align
//
// Word-alignment controller sitting between the MGT receiver (32-bit words on
// mgtclk) and sp3_demux. While SPROCKET3 transmits its interleaved training
// word, the block pulses the MGT RXSLIDE input until the received word equals
// TRAIN_PATTERN. It then requires LOCK_COUNT consecutive matches before it
// declares lock. The raw word is forwarded to sp3_demux one cycle later,
// whatever state the controller is in.
//
// Optional feature macro: SP3_SLIDE_STATS_EN
//   When defined, adds the total_slides output. It is a saturating count of
//   every rx_slide pulse since reset, and align_en does not clear it.
//
// Ports
//   mgtclk        in   1   MGT RX user clock
//   reset         in   1   asynchronous, active-high reset
//   mgtword_in    in   32  raw RX word from the MGT
//   align_en      in   1   level: 1 runs alignment, 0 returns to IDLE
//   mgtword_out   out  32  mgtword_in delayed by one cycle, to sp3_demux
//   rx_slide      out  1   one-cycle pulse to MGT RXSLIDE
//   locked        out  1   high while aligned
//   align_fail    out  1   high after MAX_SLIDES slides without alignment
//   slide_cnt     out  6   slides issued in the current attempt
//   total_slides  out  16  (SP3_SLIDE_STATS_EN only) lifetime slide count
// ---------------------------------------------------------------------------
module sp3_rx_slide_align #(
    parameter logic [31:0] TRAIN_PATTERN = 32'hA5C3_3C5A,
    parameter int unsigned SLIDE_WAIT    = 32,
    parameter int unsigned LOCK_COUNT    = 8,
    parameter int unsigned MAX_SLIDES    = 32
) (
    input  logic        mgtclk,
    input  logic        reset,
    input  logic [31:0] mgtword_in,
    input  logic        align_en,
    output logic [31:0] mgtword_out,
    output logic        rx_slide,
    output logic        locked,
    output logic        align_fail,
    output logic [5:0]  slide_cnt
`ifdef SP3_SLIDE_STATS_EN
    ,
    output logic [15:0] total_slides
`endif
);

    localparam int WAIT_W = (SLIDE_WAIT < 2) ? 1 : $clog2(SLIDE_WAIT);
    localparam int GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT);

    localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(SLIDE_WAIT - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(LOCK_COUNT - 1);
    localparam logic [5:0]        SLIDE_MAX  = 6'(MAX_SLIDES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_SLIDE,
        ST_WAIT,
        ST_VERIFY,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        slide_cnt_q, slide_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [31:0]       mgtword_q;
    logic              match;

    assign match = (mgtword_in == TRAIN_PATTERN);

    // Raw data path: a plain one-cycle register that does not depend on the FSM.
    always_ff @(posedge mgtclk or posedge reset) begin
        if (reset) begin
            mgtword_q <= '0;
        end else begin
            mgtword_q <= mgtword_in;
        end
    end

    always_ff @(posedge mgtclk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            slide_cnt_q <= '0;
            wait_cnt_q  <= '0;
            good_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            slide_cnt_q <= slide_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            good_cnt_q  <= good_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slide_cnt_d = slide_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        good_cnt_d  = good_cnt_q;

        // Dropping align_en overrides everything. Clearing the slide count here
        // makes IDLE read back zero on every output.
        if (!align_en) begin
            state_d     = ST_IDLE;
            slide_cnt_d = '0;
            wait_cnt_d  = '0;
            good_cnt_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    slide_cnt_d = '0;
                    good_cnt_d  = '0;
                    state_d     = ST_SEARCH;
                end

                ST_SEARCH: begin
                    if (match) begin
                        good_cnt_d = GOOD_W'(1);
                        state_d    = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end else if (slide_cnt_q >= SLIDE_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SLIDE;
                    end
                end

                ST_SLIDE: begin
                    if (slide_cnt_q < SLIDE_MAX) begin
                        slide_cnt_d = slide_cnt_q + 6'd1;
                    end
                    wait_cnt_d = WAIT_INIT;
                    state_d    = ST_WAIT;
                end

                // The counter leaves once its decremented value reaches zero. WAIT
                // therefore lasts SLIDE_WAIT-1 cycles. With the SLIDE and SEARCH
                // cycles added, consecutive pulses land exactly SLIDE_WAIT+1
                // cycles apart, which is the MGT's minimum spacing.
                ST_WAIT: begin
                    wait_cnt_d = (wait_cnt_q == '0) ? '0 : wait_cnt_q - WAIT_W'(1);
                    if (wait_cnt_q <= WAIT_W'(1)) begin
                        state_d = ST_SEARCH;
                    end
                end

                ST_VERIFY: begin
                    if (match) begin
                        if (good_cnt_q == GOOD_LAST) begin
                            state_d = ST_LOCKED;
                        end else begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                    end else if (slide_cnt_q < SLIDE_MAX) begin
                        state_d = ST_SLIDE;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end

                ST_LOCKED: state_d = ST_LOCKED;
                ST_FAIL:   state_d = ST_FAIL;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the registered state. Reset therefore clears
    // them immediately, and no pulse can escape after reset.
    assign rx_slide    = (state_q == ST_SLIDE);
    assign locked      = (state_q == ST_LOCKED);
    assign align_fail  = (state_q == ST_FAIL);
    assign slide_cnt   = slide_cnt_q;
    assign mgtword_out = mgtword_q;

`ifdef SP3_SLIDE_STATS_EN
    logic [15:0] total_slides_q, total_slides_d;

    always_comb begin
        total_slides_d = total_slides_q;
        if (state_q == ST_SLIDE && total_slides_q != 16'hFFFF) begin
            total_slides_d = total_slides_q + 16'd1;
        end
    end

    always_ff @(posedge mgtclk or posedge reset) begin
        if (reset) begin
            total_slides_q <= '0;
        end else begin
            total_slides_q <= total_slides_d;
        end
    end

    assign total_slides = total_slides_q;
`endif

endmodule
